// File: rtl/ldpc_enc_feeder.sv
// LDPC encoder feeder: buffers one info frame, bursts it contiguously
// into the encoder, then forwards the encoder's parity bytes downstream.
module ldpc_enc_feeder #(
  parameter int INFO_BYTES = 1024,
  parameter int PAR_BYTES  = 128,
  parameter int TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       en_start,
  output logic       en_din,
  output logic [7:0] d_in,
  output logic       read_parity,
  input  logic       done_encode,
  input  logic       en_out,
  input  logic [7:0] enc_dout,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       busy,
  output logic       frame_err
);
  localparam int IW = $clog2(INFO_BYTES);
  localparam int PW = $clog2(PAR_BYTES);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] I_MAX = IW'(INFO_BYTES - 1);
  localparam logic [PW-1:0] P_MAX = PW'(PAR_BYTES - 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FILL, START, BURST, WAIT_DONE, PARITY
  } state_t;

  state_t state, state_d;

  logic [7:0]    mem [INFO_BYTES];
  logic [IW-1:0] wcnt, rcnt, last_idx;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] wdog;
  logic          hs, fill_end, short_last, no_last;
  logic          got_done, tmo, par_hit, par_end, stray;

  assign hs         = s_valid & s_ready;
  assign fill_end   = hs & (s_last | (wcnt == I_MAX));
  assign short_last = hs & s_last & (wcnt != I_MAX);
  assign no_last    = hs & ~s_last & (wcnt == I_MAX);
  assign got_done   = (state == WAIT_DONE) & done_encode;
  assign tmo        = (state == WAIT_DONE) & ~done_encode
                    & (wdog == T_MAX);
  assign par_hit    = (state == PARITY) & en_out;
  assign par_end    = par_hit & (pcnt == P_MAX);
  assign stray      = en_out & (state != PARITY);

  assign s_ready  = (state == FILL);
  assign en_start = (state == START);
  assign en_din   = (state == BURST);
  assign busy     = (state != IDLE) && (state != FILL);

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:      state_d = FILL;
      FILL:      if (fill_end) state_d = START;
      START:     state_d = BURST;
      BURST:     if (rcnt == I_MAX) state_d = WAIT_DONE;
      WAIT_DONE: if (got_done) state_d = PARITY;
                 else if (tmo) state_d = IDLE;
      PARITY:    if (par_end) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt     <= '0;
      rcnt     <= '0;
      last_idx <= '0;
      pcnt     <= '0;
      wdog     <= '0;
    end else begin
      if (state == IDLE) begin
        wcnt <= '0;
      end else if (hs) begin
        wcnt     <= wcnt + 1'b1;
        last_idx <= wcnt;
      end
      if (state == START)      rcnt <= '0;
      else if (state == BURST) rcnt <= rcnt + 1'b1;
      if (state == BURST)          wdog <= '0;
      else if (state == WAIT_DONE) wdog <= wdog + 1'b1;
      if (state == WAIT_DONE) pcnt <= '0;
      else if (par_hit)       pcnt <= pcnt + 1'b1;
    end
  end

  // Frame buffer is plain RAM; bytes past last_idx read back as zero.
  always_ff @(posedge clk) begin
    if (hs) mem[wcnt] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_in        <= '0;
      read_parity <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      read_parity <= got_done;
      m_valid     <= par_hit;
      m_last      <= par_end;
      frame_err   <= short_last | no_last | tmo | stray;
      if (par_hit) m_data <= enc_dout;
      if (state == BURST)
        d_in <= (rcnt <= last_idx) ? mem[rcnt] : 8'h00;
    end
  end
endmodule

// File: tb/tb_ldpc_enc_feeder.sv
// Bench for ldpc_enc_feeder: frame table, parity return, timeout,
// reset abort and stray-strobe sequences against a queue-based model.
module tb_ldpc_enc_feeder;
  localparam int INFO = 1024;
  localparam int PAR  = 128;
  localparam int TMO  = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_valid = 1'b0, s_last = 1'b0;
  logic done_encode = 1'b0, en_out = 1'b0;
  logic [7:0] s_data = '0, enc_dout = '0;
  logic s_ready, en_start, en_din, read_parity;
  logic m_valid, m_last, busy, frame_err;
  logic [7:0] d_in, m_data;

  ldpc_enc_feeder #(
    .INFO_BYTES(INFO), .PAR_BYTES(PAR), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .en_start(en_start), .en_din(en_din), .d_in(d_in),
    .read_parity(read_parity), .done_encode(done_encode),
    .en_out(en_out), .enc_dout(enc_dout),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_start = 0, n_din = 0, n_runs = 0;
  int n_err = 0, n_rp = 0, n_last = 0, last_pos = -1;
  int wd_cyc = -1, err_cyc = -1;
  bit din_prev = 1'b0;
  byte unsigned dq[$], mq[$], sent[$], psent[$];

  always @(negedge clk) begin
    cyc++;
    if (din_prev) dq.push_back(d_in);
    if (en_din && !din_prev) n_runs++;
    if (!en_din && din_prev) wd_cyc = cyc;
    if (en_din) n_din++;
    din_prev = en_din;
    if (en_start) n_start++;
    if (frame_err) begin n_err++; err_cyc = cyc; end
    if (read_parity) n_rp++;
    if (m_valid) begin
      mq.push_back(m_data);
      if (m_last) begin
        n_last++;
        last_pos = int'(mq.size()) - 1;
      end
    end
  end

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    n_start = 0; n_din = 0; n_runs = 0; n_err = 0; n_rp = 0;
    n_last = 0; last_pos = -1; wd_cyc = -1; err_cyc = -1;
    din_prev = en_din;
    dq.delete(); mq.delete();
  endtask

  task automatic send_frame(input int len, input bit last,
                            input bit inc);
    sent.delete();
    for (int i = 0; i < len; i++) begin
      int guard = 0;
      if ($urandom_range(3) == 0) begin s_valid = 1'b0; tick(); end
      s_valid = 1'b1;
      s_data  = inc ? 8'(i) : 8'($urandom);
      s_last  = last && (i == len - 1);
      while (!s_ready && guard < 5000) begin tick(); guard++; end
      if (!s_ready) begin
        check("fill_ready_wait", 0, 1);
        break;
      end
      sent.push_back(s_data);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_wd();
    int guard = 0;
    while ((n_din < INFO || en_din) && guard < 3000) begin
      tick(); guard++;
    end
    check("burst_end_wait", (n_din >= INFO && !en_din), 1);
  endtask

  task automatic do_parity(input bit inc);
    int guard = 0;
    psent.delete();
    repeat ($urandom_range(3)) tick();
    done_encode = 1'b1; tick(); done_encode = 1'b0;
    while (n_rp == 0 && guard < 100) begin tick(); guard++; end
    check("read_parity_wait", (n_rp > 0), 1);
    for (int i = 0; i < PAR; i++) begin
      if ($urandom_range(3) == 0) begin en_out = 1'b0; tick(); end
      en_out   = 1'b1;
      enc_dout = inc ? 8'(8'h80 + i) : 8'($urandom);
      psent.push_back(enc_dout);
      tick();
    end
    en_out = 1'b0;
    repeat (3) tick();
  endtask

  // Expected burst = accepted bytes, zero-padded to a full frame.
  task automatic check_frame(input string tag, input int exp_err);
    int bad = -1;
    for (int i = 0; i < INFO; i++) begin
      byte unsigned e;
      e = (i < int'(sent.size())) ? sent[i] : 8'h00;
      if (i >= int'(dq.size()) || dq[i] != e) begin bad = i; break; end
    end
    check({tag, "_en_start"}, n_start, 1);
    check({tag, "_en_din_cycles"}, n_din, INFO);
    check({tag, "_en_din_runs"}, n_runs, 1);
    check({tag, "_d_in_first_bad_idx"}, bad, -1);
    check({tag, "_frame_err"}, n_err, exp_err);
  endtask

  task automatic check_parity(input string tag);
    int bad = -1;
    for (int i = 0; i < PAR; i++)
      if (i >= int'(mq.size()) || mq[i] != psent[i]) begin
        bad = i; break;
      end
    check({tag, "_read_parity"}, n_rp, 1);
    check({tag, "_m_valid_count"}, mq.size(), PAR);
    check({tag, "_m_data_first_bad_idx"}, bad, -1);
    check({tag, "_m_last_count"}, n_last, 1);
    check({tag, "_m_last_pos"}, last_pos, PAR - 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  typedef struct {
    int len;
    bit last;
    bit inc;
    int exp_err;
  } vec_t;

  vec_t vt[6];

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    vt[0] = '{1024, 1'b1, 1'b1, 0};
    vt[1] = '{100,  1'b1, 1'b0, 1};
    vt[2] = '{1024, 1'b0, 1'b0, 1};
    vt[3] = '{1,    1'b1, 1'b0, 1};
    vt[4] = '{1023, 1'b1, 1'b0, 1};
    vt[5] = '{1024, 1'b1, 1'b0, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {s_ready, en_start, en_din, d_in, read_parity,
           m_valid, m_data, m_last, busy, frame_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_1st_edge", s_ready, 0);
    tick();
    check("ready_after_1st_edge", s_ready, 1);

    clear_mon();
    en_out = 1'b1; enc_dout = 8'h55; done_encode = 1'b1;
    tick();
    en_out = 1'b0; done_encode = 1'b0;
    repeat (3) tick();
    check("stray_en_out_err", n_err, 1);
    check("stray_en_out_m_valid", mq.size(), 0);
    check("stray_done_read_parity", n_rp, 0);
    check("stray_busy", busy, 0);

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      clear_mon();
      send_frame(vt[v].len, vt[v].last, vt[v].inc);
      wait_wd();
      check({tag, "_busy_wait_done"}, busy, 1);
      do_parity(v == 0);
      check_frame(tag, vt[v].exp_err);
      check_parity(tag);
    end

    begin
      int guard = 0;
      clear_mon();
      send_frame(INFO, 1'b1, 1'b0);
      wait_wd();
      while (n_err == 0 && guard < TMO + 200) begin tick(); guard++; end
      check("tmo_err_delay", err_cyc - wd_cyc, TMO);
      check("tmo_err_count", n_err, 1);
      check("tmo_read_parity", n_rp, 0);
      check("tmo_busy", busy, 0);
    end

    begin
      int guard = 0;
      clear_mon();
      send_frame(INFO, 1'b1, 1'b0);
      while (n_din < 500 && guard < 3000) begin tick(); guard++; end
      rst_n = 1'b0;
      #1;
      check("rst_burst_en_din", en_din, 0);
      check("rst_burst_busy", busy, 0);
      check("rst_burst_d_in", d_in, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      clear_mon();
      send_frame(INFO, 1'b1, 1'b0);
      wait_wd();
      do_parity(1'b0);
      check_frame("post_rst", 0);
      check_parity("post_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
